mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register. Turns the registered
//  memREN/memWEN/address/store-data into a dcache request held until dhit.
//  Raises stallDmem back to the EX/MEM register and hazard unit while a miss
//  is pending, and hands load data to MEM/WB.
//  Ensures each memory instruction is issued to the cache exactly once, even
//  while the pipeline is frozen by another hazard.
// PARAMETERS
//  WORD_W  32  data/address width (cpu_types_pkg word_t)
//  CNT_W   16  width of the saturating performance counters
// PORTS
//  CLK         in   1       clock; all state on rising edge
//  RST         in   1       synchronous reset, active-high
//  ex_valid    in   1       EX/MEM output holds a live instruction
//  flushed     in   1       EX/MEM entry squashed (treat as bubble)
//  memREN      in   1       entry is a load
//  memWEN      in   1       entry is a store
//  mem_addr    in   WORD_W  ALU result = effective address
//  mem_wdata   in   WORD_W  rdat2 forwarded store data
//  hold        in   1       pipeline frozen by a non-dmem source; EX/MEM entry will not advance
//  dhit        in   1       cache completes the current request this cycle
//  dmemload    in   WORD_W  cache read data, valid when dhit
//  dmemREN     out  1       cache read request
//  dmemWEN     out  1       cache write request
//  dmemaddr    out  WORD_W  cache address
//  dmemstore   out  WORD_W  cache write data
//  stallDmem   out  1       pending access; freeze PC..EX/MEM, bubble MEM/WB
//  ld_data     out  WORD_W  load result to MEM/WB
//  mem_done    out  1       access of current entry completed (this or earlier cycle)
//  err_both    out  1       1-cycle pulse: memREN&memWEN both set (illegal)
//  stall_cnt   out  CNT_W   cycles with stallDmem=1, saturating
//  access_cnt  out  CNT_W   completed accesses, saturating
// BEHAVIOUR
//  req = ex_valid & ~flushed & (memREN|memWEN). Both set: handled as a store; err_both pulses.
//  FSM: IDLE, WAIT, DONE. Reset -> IDLE.
//  All outputs 0 in reset. Counters clear to 0. ld_q clears to 0.
//  IDLE:
//   - Request is combinational from the EX/MEM inputs, with zero added latency.
//   - dmemREN/dmemWEN/dmemaddr/dmemstore are driven from the inputs when req=1.
//   - req & dhit: mem_done=1, stallDmem=0, and ld_data=dmemload; ld_q<=dmemload.
//     Next state: DONE if hold, else IDLE.
//   - req & ~dhit: stallDmem=1. Latch addr, wdata, type. Next state: WAIT.
//   - ~req: all requests 0, stallDmem=0, mem_done=0.
//  WAIT:
//   - Drive the latched request, not live inputs. stallDmem=1 until dhit.
//   - On dhit: stallDmem=0, mem_done=1, ld_data=dmemload; ld_q<=dmemload.
//     Next state: DONE if hold, else IDLE.
//   - flushed during WAIT does not abort. The access completes to keep the
//     cache handshake legal, and mem_done is forced to 0 on completion.
//  DONE:
//   - Requests 0, stallDmem=0, mem_done=1, ld_data=ld_q. The same entry must
//     not be re-issued.
//   - Stay while hold=1. Go to IDLE when hold=0, because the entry advances on that edge.
//  ld_data = ld_q whenever no dhit is present this cycle.
//  Stores leave ld_q unchanged.
//  stall_cnt += 1 each cycle stallDmem=1. access_cnt += 1 each dhit. Both hold at all-ones.
//  RST mid-WAIT: return to IDLE next edge. Requests drop, and the dhit of the aborted access is ignored.
//  dhit while no request is outstanding: ignored, with no state or counter change.
// TESTING
//  1 Load, dhit same cycle (addr=0x100, dmemload=0xDEADBEEF)
//    -> dmemREN=1 for 1 cycle, stallDmem=0, ld_data=0xDEADBEEF, access_cnt=1.
//  2 Store miss, dhit after 3 cycles (addr=0x204, wdata=0x12345678)
//    -> dmemWEN held 4 cycles with a stable address/data, stallDmem=1 for 3 cycles, stall_cnt=3.
//  3 Load hit with hold=1 for 2 more cycles
//    -> DONE for 2 cycles, dmemREN=0, ld_data=0xCAFEF00D held, no second request.
//  4 flushed rises in WAIT for a load
//    -> request held until dhit, mem_done=0 at completion, then IDLE.
//  5 memREN=memWEN=1
//    -> dmemWEN=1, dmemREN=0, err_both pulses 1 cycle.
//  6 RST asserted in WAIT
//    -> next cycle all outputs 0 and state IDLE; counters saturate at 0xFFFF under forced long stall.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache access controller: issues each EX/MEM memory entry to
// the dcache exactly once, stalls the pipeline on a miss, returns load data.
module mem_access_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  input  logic              flushed,
  input  logic              memREN,
  input  logic              memWEN,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic              hold,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              stallDmem,
  output logic [WORD_W-1:0] ld_data,
  output logic              mem_done,
  output logic              err_both,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  access_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_ld_q;
  logic              r_is_store;
  logic              r_flush_seen;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_access_cnt;
  logic              w_req;
  logic              w_latch;
  logic              w_complete;
  logic              w_cpl_load;

  assign w_req      = ex_valid & ~flushed & (memREN | memWEN);
  assign stall_cnt  = r_stall_cnt;
  assign access_cnt = r_access_cnt;

  // State, latched request, load data and saturating counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ld_q       <= '0;
      r_is_store   <= 1'b0;
      r_flush_seen <= 1'b0;
      r_stall_cnt  <= '0;
      r_access_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr       <= mem_addr;
        r_wdata      <= mem_wdata;
        r_is_store   <= memWEN;
        r_flush_seen <= 1'b0;
      end else if ((r_state == S_WAIT) && flushed) begin
        r_flush_seen <= 1'b1;
      end
      if (w_cpl_load) begin
        r_ld_q <= dmemload;
      end
      if (stallDmem && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_complete && (r_access_cnt != CNT_MAX)) begin
        r_access_cnt <= r_access_cnt + CNT_ONE;
      end
    end
  end

  // Next-state and cache/pipeline outputs; everything is forced quiet during reset
  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_complete = 1'b0;
    w_cpl_load = 1'b0;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dmemaddr   = '0;
    dmemstore  = '0;
    stallDmem  = 1'b0;
    mem_done   = 1'b0;
    err_both   = 1'b0;
    ld_data    = r_ld_q;
    if (RST) begin
      w_next  = S_IDLE;
      ld_data = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // both flags set is treated as a store
            dmemREN   = memREN & ~memWEN;
            dmemWEN   = memWEN;
            dmemaddr  = mem_addr;
            dmemstore = mem_wdata;
            err_both  = memREN & memWEN;
            if (dhit) begin
              w_complete = 1'b1;
              w_cpl_load = ~memWEN;
              mem_done   = 1'b1;
              ld_data    = dmemload;
              w_next     = hold ? S_DONE : S_IDLE;
            end else begin
              stallDmem = 1'b1;
              w_latch   = 1'b1;
              w_next    = S_WAIT;
            end
          end else begin
            w_next = S_IDLE;
          end
        end
        S_WAIT: begin
          dmemREN   = ~r_is_store;
          dmemWEN   = r_is_store;
          dmemaddr  = r_addr;
          dmemstore = r_wdata;
          if (dhit) begin
            // a squashed entry still finishes its handshake but reports no completion
            w_complete = 1'b1;
            w_cpl_load = ~r_is_store;
            mem_done   = ~(flushed | r_flush_seen);
            ld_data    = dmemload;
            w_next     = hold ? S_DONE : S_IDLE;
          end else begin
            stallDmem = 1'b1;
          end
        end
        S_DONE: begin
          mem_done = 1'b1;
          w_next   = hold ? S_DONE : S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

endmodule
